// File: rtl/spi_fifo_pkg.sv
// Shared definitions for the SPI FIFO front end: register offsets,
// controller state encoding and STAT register bit positions.
package spi_fifo_pkg;

    // Register offsets as decoded from addr[3:2]
    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_STAT = 2'd1;
    localparam logic [1:0] REG_CTRL = 2'd2;

    // Burst sequencer states
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        START,
        WAIT,
        HOLD
    } state_t;

    // STAT register bit positions
    localparam int unsigned STAT_RX_EMPTY = 0;
    localparam int unsigned STAT_RX_FULL  = 1;
    localparam int unsigned STAT_TX_FULL  = 2;
    localparam int unsigned STAT_BUSY     = 3;
    localparam int unsigned STAT_RX_OVF   = 4;
    localparam int unsigned STAT_TX_OVF   = 5;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO. A push to a full FIFO and a pop from an empty FIFO are
// ignored; fullness/emptiness are judged on the state before this cycle's
// operations, so a simultaneous push and pop both take effect when legal.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end
    end

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/spi_fifo_ctrl.sv
// Memory-mapped front end for the byte-level SPI engine: TX/RX buffering,
// automatic chip-select over a burst, sticky overflow flags and RX irq.
module spi_fifo_ctrl
    import spi_fifo_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned SS_HOLD = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid,
    output logic        ready,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        eng_start,
    output logic [7:0]  eng_tx,
    input  logic        eng_done,
    input  logic [7:0]  eng_rx,
    output logic        ss_n,
    output logic        irq
);

    localparam int unsigned CNT_W = $clog2(SS_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(SS_HOLD - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ss_n_d;
    logic [7:0]       eng_tx_d;

    logic        bus_acc, bus_wr;
    logic [1:0]  bus_reg;
    logic [31:0] rdata_d;
    logic        tx_push, tx_pop, tx_full, tx_empty;
    logic        rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]  tx_head, rx_head;
    logic        tx_ovf, rx_ovf, ss_force, busy;
    logic        unused_bits;

    // One access per request: ready is never asserted on back-to-back cycles
    assign bus_acc     = valid && !ready;
    assign bus_wr      = |wstrb;
    assign bus_reg     = addr[3:2];
    assign tx_push     = bus_acc && bus_wr && (bus_reg == REG_DATA);
    assign rx_pop      = bus_acc && !bus_wr && (bus_reg == REG_DATA);
    assign busy        = (state_q != IDLE);
    assign eng_start   = (state_q == START);
    assign irq         = !rx_empty;
    assign unused_bits = ^{addr[31:4], addr[1:0], wdata[31:8]};

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
        .clk(clk), .resetn(resetn), .push(tx_push), .pop(tx_pop),
        .din(wdata[7:0]), .full(tx_full), .empty(tx_empty), .head(tx_head)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
        .clk(clk), .resetn(resetn), .push(rx_push), .pop(rx_pop),
        .din(eng_rx), .full(rx_full), .empty(rx_empty), .head(rx_head)
    );

    // Read data mux; sampled on the accept edge so it is valid with ready
    always_comb begin
        rdata_d = '0;
        if (bus_acc && !bus_wr) begin
            case (bus_reg)
                REG_DATA: rdata_d = {23'b0, rx_empty, rx_empty ? 8'h00 : rx_head};
                REG_STAT: begin
                    rdata_d[STAT_RX_EMPTY] = rx_empty;
                    rdata_d[STAT_RX_FULL]  = rx_full;
                    rdata_d[STAT_TX_FULL]  = tx_full;
                    rdata_d[STAT_BUSY]     = busy;
                    rdata_d[STAT_RX_OVF]   = rx_ovf;
                    rdata_d[STAT_TX_OVF]   = tx_ovf;
                end
                REG_CTRL: rdata_d = {31'b0, ss_force};
                default:  rdata_d = '0;
            endcase
        end
    end

    // Bus acknowledge, read data, control bit and sticky overflow flags
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready    <= 1'b0;
            rdata    <= '0;
            tx_ovf   <= 1'b0;
            rx_ovf   <= 1'b0;
            ss_force <= 1'b0;
        end else begin
            ready <= bus_acc;
            rdata <= rdata_d;
            if (bus_acc && bus_wr && (bus_reg == REG_STAT)) begin
                if (wdata[0]) rx_ovf <= 1'b0;
                if (wdata[1]) tx_ovf <= 1'b0;
            end
            if (bus_acc && bus_wr && (bus_reg == REG_CTRL)) ss_force <= wdata[0];
            // A new overflow event wins over a same-cycle clear
            if (tx_push && tx_full) tx_ovf <= 1'b1;
            if (rx_push && rx_full) rx_ovf <= 1'b1;
        end
    end

    // Sequencer state, SS counter, chip select and engine byte registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ss_n    <= 1'b1;
            eng_tx  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ss_n    <= ss_n_d;
            eng_tx  <= eng_tx_d;
        end
    end

    // Next-state logic: eng_tx is loaded on entry to START, TX pops during START
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ss_n_d   = ss_n;
        eng_tx_d = eng_tx;
        tx_pop   = 1'b0;
        rx_push  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!tx_empty) begin
                    state_d = SETUP;
                    ss_n_d  = 1'b0;
                    cnt_d   = HOLD_INIT;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d  = START;
                    eng_tx_d = tx_head;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            START: begin
                tx_pop  = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (eng_done) begin
                    rx_push = 1'b1;
                    if (!tx_empty) begin
                        state_d  = START;
                        eng_tx_d = tx_head;
                    end else begin
                        state_d = HOLD;
                        cnt_d   = HOLD_INIT;
                    end
                end
            end
            HOLD: begin
                if (!tx_empty) begin
                    state_d  = START;
                    eng_tx_d = tx_head;
                end else if (ss_force) begin
                    cnt_d = HOLD_INIT;
                end else if (cnt_q == '0) begin
                    state_d = IDLE;
                    ss_n_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_fifo_ctrl.sv
// Scoreboard bench for spi_fifo_ctrl: a queue-based reference model predicts
// every bus read and every engine byte; monitors compare as the DUT responds.
module tb_spi_fifo_ctrl;

    localparam int DEPTH   = 8;
    localparam int SS_HOLD = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        valid = 1'b0;
    logic        ready;
    logic [31:0] addr = '0;
    logic [3:0]  wstrb = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        eng_start;
    logic [7:0]  eng_tx;
    logic        eng_done = 1'b0;
    logic [7:0]  eng_rx = '0;
    logic        ss_n;
    logic        irq;

    spi_fifo_ctrl #(.DEPTH(DEPTH), .SS_HOLD(SS_HOLD)) dut (
        .clk(clk), .resetn(resetn), .valid(valid), .ready(ready),
        .addr(addr), .wstrb(wstrb), .wdata(wdata), .rdata(rdata),
        .eng_start(eng_start), .eng_tx(eng_tx), .eng_done(eng_done),
        .eng_rx(eng_rx), .ss_n(ss_n), .irq(irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] val;
        logic [31:0] mask;
        bit          do_chk;
    } exp_t;

    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    exp_t       exp_q[$];
    bit         m_txovf = 0, m_rxovf = 0, m_force = 0;
    bit         stray = 0, eng_stall = 0, rnd_mode = 0;
    int         rst_gen = 0;

    always @(negedge resetn) rst_gen++;

    always @(posedge clk or negedge resetn) begin : model
        int         txn, rxn;
        bit         acc, wr;
        logic [1:0] ra;
        exp_t       e;
        if (!resetn) begin
            txq.delete(); rxq.delete(); exp_q.delete();
            m_txovf = 0; m_rxovf = 0; m_force = 0;
        end else begin
            txn = txq.size();
            rxn = rxq.size();
            acc = valid && !ready;
            wr  = (wstrb != 4'h0);
            ra  = addr[3:2];
            e.val = '0; e.mask = '1; e.do_chk = !wr;
            if (acc) begin
                case (ra)
                    2'd0: begin
                        if (wr) begin
                            if (txn == DEPTH) m_txovf = 1;
                            else txq.push_back(wdata[7:0]);
                        end else begin
                            e.val = (rxn == 0) ? 32'h100 : {24'h0, rxq[0]};
                        end
                    end
                    2'd1: begin
                        if (wr) begin
                            if (wdata[0]) m_rxovf = 0;
                            if (wdata[1]) m_txovf = 0;
                        end else begin
                            // busy depends on sequencer timing; directed tests cover it
                            e.val  = {26'b0, m_txovf, m_rxovf, 1'b0, txn == DEPTH, rxn == DEPTH, rxn == 0};
                            e.mask = ~32'h8;
                        end
                    end
                    2'd2: begin
                        if (wr) m_force = wdata[0];
                        else e.val = {31'b0, m_force};
                    end
                    default: e.val = '0;
                endcase
                exp_q.push_back(e);
            end
            if (eng_start && txq.size() > 0) void'(txq.pop_front());
            if (eng_done && !stray) begin
                if (rxn == DEPTH) m_rxovf = 1;
                else rxq.push_back(eng_rx);
            end
            if (acc && !wr && ra == 2'd0 && rxn > 0) void'(rxq.pop_front());
        end
    end

    // ---------------- monitors ----------------
    bit   prev_ready = 0;
    exp_t me;
    always @(negedge clk) begin
        if (resetn) begin
            if (ready) begin
                chk("ready_single_cycle", {31'b0, prev_ready}, 0);
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_unexpected_ready actual=ready expected=no_ack");
                end else begin
                    me = exp_q.pop_front();
                    if (me.do_chk) chk("sb_rdata", rdata & me.mask, me.val & me.mask);
                end
                chk("sb_irq", {31'b0, irq}, {31'b0, rxq.size() != 0});
            end
            if (eng_start) begin
                if (txq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_eng_start actual=start expected=no_start(tx_empty)");
                end else begin
                    chk("sb_eng_tx", {24'h0, eng_tx}, {24'h0, txq[0]});
                end
                chk("sb_ss_at_start", {31'b0, ss_n}, 0);
            end
        end
        prev_ready = ready;
    end

    // ---------------- engine responder ----------------
    initial begin : engine
        int         g, d;
        logic [7:0] b;
        forever begin
            if (resetn && eng_start) begin
                g = rst_gen;
                b = eng_tx;
                d = rnd_mode ? $urandom_range(0, 3) : 0;
                while (eng_stall && g == rst_gen) @(negedge clk);
                repeat (1 + d) @(negedge clk);
                if (g == rst_gen && resetn) begin
                    eng_done = 1'b1;
                    eng_rx   = rnd_mode ? 8'($urandom) : (b ^ 8'hFF);
                    @(negedge clk);
                    eng_done = 1'b0;
                end
            end else begin
                @(negedge clk);
            end
        end
    end

    // ---------------- bus helpers ----------------
    task automatic bus(input logic [1:0] ra, input bit wr, input logic [31:0] d, output logic [31:0] r);
        int n;
        @(negedge clk);
        valid = 1'b1;
        addr  = ($urandom() & 32'hFFFF_FFF3) | {28'h0, ra, 2'b00};
        wstrb = wr ? 4'($urandom_range(1, 15)) : 4'h0;
        wdata = d;
        n = 0;
        do begin @(negedge clk); n++; end while (!ready && n < 8);
        chk("bus_ack", {31'b0, ready}, 1);
        r = rdata;
        valid = 1'b0;
        wstrb = 4'h0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((txq.size() != 0 || ss_n !== 1'b1) && n < 400) begin @(negedge clk); n++; end
        chk(nm, {31'b0, ss_n}, 1);
    endtask

    task automatic wait_start(input string nm);
        int n = 0;
        while (eng_start !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk(nm, {31'b0, eng_start}, 1);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin : main
        logic [31:0] r;
        logic [1:0]  ra;
        bit          wr;
        int          gaps;

        repeat (3) @(negedge clk);
        chk("rst_ss_n", {31'b0, ss_n}, 1);
        chk("rst_ready", {31'b0, ready}, 0);
        chk("rst_eng_start", {31'b0, eng_start}, 0);
        chk("rst_irq", {31'b0, irq}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_eng_tx", {24'h0, eng_tx}, 0);
        resetn = 1'b1;

        // 1: single byte latency and SS hold
        bus(2'd0, 1, 32'hA5, r);
        chk("t1_ss_at_ack", {31'b0, ss_n}, 1);
        @(negedge clk);
        chk("t1_ss_fall", {31'b0, ss_n}, 0);
        chk("t1_no_start_early", {31'b0, eng_start}, 0);
        repeat (SS_HOLD - 1) begin
            @(negedge clk);
            chk("t1_no_start_setup", {31'b0, eng_start}, 0);
        end
        @(negedge clk);
        chk("t1_start", {31'b0, eng_start}, 1);
        chk("t1_tx", {24'h0, eng_tx}, 32'hA5);
        repeat (1 + SS_HOLD) begin
            @(negedge clk);
            chk("t1_ss_hold", {31'b0, ss_n}, 0);
        end
        @(negedge clk);
        chk("t1_ss_rise", {31'b0, ss_n}, 1);
        bus(2'd0, 0, 0, r);
        chk("t1_rx", r, 32'h05A);

        // 2: three-byte burst keeps SS low throughout
        bus(2'd0, 1, 32'h01, r);
        bus(2'd0, 1, 32'h02, r);
        bus(2'd0, 1, 32'h03, r);
        gaps = 0;
        for (int i = 0; i < 60 && rxq.size() < 3; i++) begin
            if (ss_n !== 1'b0) gaps++;
            @(negedge clk);
        end
        chk("t2_ss_gap", gaps, 0);
        wait_idle("t2_idle");
        bus(2'd0, 0, 0, r); chk("t2_rd0", r, 32'h0FE);
        bus(2'd0, 0, 0, r); chk("t2_rd1", r, 32'h0FD);
        bus(2'd0, 0, 0, r); chk("t2_rd2", r, 32'h0FC);
        bus(2'd0, 0, 0, r); chk("t2_rd_empty", r, 32'h100);

        // 3: TX overflow with a stalled engine
        eng_stall = 1;
        for (int i = 0; i <= DEPTH; i++) bus(2'd0, 1, 32'h10 + i, r);
        bus(2'd1, 0, 0, r); chk("t3_stat_full", r, 32'h0D);
        bus(2'd0, 1, 32'h10 + DEPTH + 1, r);
        bus(2'd1, 0, 0, r); chk("t3_stat_ovf", r, 32'h2D);
        bus(2'd1, 1, 32'h2, r);
        bus(2'd1, 0, 0, r); chk("t3_stat_clr", r, 32'h0D);
        eng_stall = 0;

        // 4: RX overflow, order preserved, irq until drained
        wait_idle("t4_idle");
        bus(2'd1, 0, 0, r); chk("t4_stat", r, 32'h12);
        for (int i = 0; i < DEPTH; i++) begin
            chk("t4_irq_high", {31'b0, irq}, 1);
            bus(2'd0, 0, 0, r);
            chk("t4_rx_order", r, {24'h0, 8'(32'h10 + i) ^ 8'hFF});
        end
        chk("t4_irq_low", {31'b0, irq}, 0);
        bus(2'd0, 0, 0, r); chk("t4_rd_empty", r, 32'h100);
        bus(2'd1, 1, 32'h1, r);
        bus(2'd1, 0, 0, r); chk("t4_stat_clr", r, 32'h01);

        // 5: ss_force keeps SS low until cleared
        bus(2'd2, 1, 32'h1, r);
        bus(2'd2, 0, 0, r); chk("t5_ctrl", r, 32'h1);
        bus(2'd0, 1, 32'h5A, r);
        wait_start("t5_start");
        gaps = 0;
        repeat (20) begin
            @(negedge clk);
            if (ss_n !== 1'b0) gaps++;
        end
        chk("t5_ss_forced", gaps, 0);
        bus(2'd2, 1, 32'h0, r);
        chk("t5_ss_after_clr", {31'b0, ss_n}, 0);
        repeat (SS_HOLD - 1) begin
            @(negedge clk);
            chk("t5_ss_hold", {31'b0, ss_n}, 0);
        end
        @(negedge clk);
        chk("t5_ss_rise", {31'b0, ss_n}, 1);
        bus(2'd0, 0, 0, r); chk("t5_rx", r, 32'h0A5);

        // randomized traffic against the model
        rnd_mode = 1;
        for (int i = 0; i < 300; i++) begin
            ra = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) != 0) ra = 2'd0;
            wr = 1'($urandom_range(0, 1));
            bus(ra, wr, $urandom, r);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        bus(2'd2, 1, 32'h0, r);
        wait_idle("rnd_idle");
        rnd_mode = 0;
        for (int i = 0; i < 2 * DEPTH && rxq.size() > 0; i++) bus(2'd0, 0, 0, r);
        bus(2'd1, 1, 32'h3, r);

        // 6: asynchronous reset in the middle of a byte
        eng_stall = 1;
        bus(2'd0, 1, 32'h77, r);
        wait_start("t6_start");
        @(negedge clk);
        chk("t6_ss_low_pre", {31'b0, ss_n}, 0);
        #2 resetn = 1'b0;
        #1;
        chk("t6_ss_n", {31'b0, ss_n}, 1);
        chk("t6_eng_start", {31'b0, eng_start}, 0);
        chk("t6_ready", {31'b0, ready}, 0);
        chk("t6_eng_tx", {24'h0, eng_tx}, 0);
        eng_stall = 0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        bus(2'd1, 0, 0, r); chk("t6_stat", r, 32'h01);
        // eng_done outside WAIT must not capture anything
        stray = 1;
        @(negedge clk); eng_rx = 8'h3C; eng_done = 1'b1;
        @(negedge clk); eng_done = 1'b0;
        stray = 0;
        bus(2'd0, 0, 0, r); chk("t6_stray_done", r, 32'h100);
        bus(2'd3, 0, 0, r); chk("t6_reg3", r, 32'h0);

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
